// File: rtl/router_in_arbiter.sv
// Packet-level round-robin arbiter feeding the single input port of the 1x3 router.
// One source owns the port from header through parity; an idle gap separates packets.
module router_in_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 64,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic                  router_busy,
  output logic [2:0]            grant,
  output logic [2:0]            ready,
  output logic                  pkt_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [6:0]            byte_cnt,
  output logic                  err_overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PASS   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam logic [6:0] MAX_CNT  = 7'(MAX_BYTES);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic       err_overrun_q, err_overrun_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [2:0] blocked_q, blocked_d;

  logic [1:0] sel;
  logic       req_sel;
  logic [2:0] eligible;
  logic       enter_gap;

  // Search order starts just after the most recently served source.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
    case (last)
      2'd0: begin
        if      (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
        else if (r[0]) g = 3'b001;
      end
      2'd1: begin
        if      (r[2]) g = 3'b100;
        else if (r[0]) g = 3'b001;
        else if (r[1]) g = 3'b010;
      end
      default: begin
        if      (r[0]) g = 3'b001;
        else if (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [2:0] g);
    return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
  endfunction

  assign sel      = onehot_idx(grant_q);
  assign req_sel  = req[sel];
  // A source cut off by an overrun stays masked until it drops req once.
  assign eligible = req & ~blocked_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    byte_cnt_d    = byte_cnt_q;
    err_overrun_d = 1'b0;
    gap_cnt_d     = gap_cnt_q;
    blocked_d     = blocked_q & req;
    enter_gap     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          grant_d    = rr_pick(eligible, last_q);
          byte_cnt_d = '0;
          state_d    = S_PASS;
        end
      end

      S_PASS: begin
        if (req_sel) begin
          if (!router_busy) begin
            if (byte_cnt_q == MAX_CNT) begin
              err_overrun_d  = 1'b1;
              blocked_d[sel] = 1'b1;
              enter_gap      = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 7'd1;
            end
          end
        end else if (!router_busy) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
          enter_gap  = 1'b1;
        end else begin
          state_d = S_PARITY;
        end
      end

      S_PARITY: begin
        if (!router_busy) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
          enter_gap  = 1'b1;
        end
      end

      default: begin
        // The final gap cycle also arbitrates, so back-to-back packets are
        // separated by exactly GAP_CYCLES idle cycles.
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else if (|eligible) begin
          grant_d    = rr_pick(eligible, last_q);
          byte_cnt_d = '0;
          state_d    = S_PASS;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (enter_gap) begin
      grant_d   = 3'b000;
      last_d    = sel;
      gap_cnt_d = GAP_LOAD;
      state_d   = S_GAP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_q       <= 3'b000;
      last_q        <= 2'd2;
      byte_cnt_q    <= '0;
      err_overrun_q <= 1'b0;
      gap_cnt_q     <= '0;
      blocked_q     <= 3'b000;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      byte_cnt_q    <= byte_cnt_d;
      err_overrun_q <= err_overrun_d;
      gap_cnt_q     <= gap_cnt_d;
      blocked_q     <= blocked_d;
    end
  end

  always_comb begin
    data_out = '0;
    case (grant_q)
      3'b001:  data_out = data_in_0;
      3'b010:  data_out = data_in_1;
      3'b100:  data_out = data_in_2;
      default: data_out = '0;
    endcase
  end

  assign grant       = grant_q;
  assign ready       = grant_q & {3{~router_busy}};
  assign pkt_valid   = (state_q == S_PASS) & req_sel;
  assign byte_cnt    = byte_cnt_q;
  assign err_overrun = err_overrun_q;

endmodule
